// File: rtl/alu_sequencer.sv
// Single-issue command sequencer driving the 3-port register file and ALU.
// ALU ops walk READ -> EXEC -> WRITE; immediate loads go straight to WRITE.
module alu_sequencer #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned AWIDTH = 2,
  parameter int unsigned IWIDTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_LOAD,
  input  logic [IWIDTH-1:0] CMD_OP,
  input  logic [AWIDTH-1:0] CMD_DST,
  input  logic [AWIDTH-1:0] CMD_SRCA,
  input  logic [AWIDTH-1:0] CMD_SRCB,
  input  logic [WIDTH-1:0]  CMD_IMM,
  input  logic              CMD_USE_FLAG,
  output logic [AWIDTH-1:0] A_ADDR,
  output logic [AWIDTH-1:0] B_ADDR,
  output logic [AWIDTH-1:0] C_ADDR,
  output logic              C_WE,
  output logic              C_SEL,
  output logic [WIDTH-1:0]  C_DIN,
  output logic [IWIDTH-1:0] ALU_INSTR,
  output logic              ALU_CIN,
  output logic              ALU_BIN,
  input  logic              ALU_COUT,
  input  logic              ALU_BOUT,
  output logic              CARRY_FLAG,
  output logic              BORROW_FLAG,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   accept;

  assign CMD_READY = (state_q == IDLE) && !RST;
  assign accept    = CMD_VALID && CMD_READY;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CMD_LOAD ? WRITE : READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched command fields, flags and registered strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      A_ADDR      <= '0;
      B_ADDR      <= '0;
      C_ADDR      <= '0;
      C_DIN       <= '0;
      ALU_INSTR   <= '0;
      ALU_CIN     <= 1'b0;
      ALU_BIN     <= 1'b0;
      CARRY_FLAG  <= 1'b0;
      BORROW_FLAG <= 1'b0;
      C_WE        <= 1'b0;
      C_SEL       <= 1'b0;
      DONE        <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      if (accept) begin
        A_ADDR    <= CMD_SRCA;
        B_ADDR    <= CMD_SRCB;
        C_ADDR    <= CMD_DST;
        C_DIN     <= CMD_IMM;
        ALU_INSTR <= CMD_OP;
        // Carry/borrow in use the flags from before this command and stay put through WRITE
        ALU_CIN   <= CMD_USE_FLAG && CARRY_FLAG;
        ALU_BIN   <= CMD_USE_FLAG && BORROW_FLAG;
      end
      if (state_q == EXEC) begin
        CARRY_FLAG  <= ALU_COUT;
        BORROW_FLAG <= ALU_BOUT;
      end
      C_WE  <= (state_d == WRITE);
      DONE  <= (state_d == WRITE);
      // Only an immediate load enters WRITE directly from IDLE
      C_SEL <= (state_q == IDLE) && (state_d == WRITE);
      BUSY  <= (state_d != IDLE);
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Single-issue controller that sequences the 3-port register file (two read ports A/B, one write port C) and the ALU as one datapath. It accepts one command per handshake: either a register-to-register ALU operation or an immediate load. It drives the read/write addresses, ALU opcode, carry/borrow inputs, write-data select and write enable, and keeps architectural carry and borrow flags. It sits between a command source (test FSM or future instruction decoder) and the datapath top level.

Parameters:
WIDTH, 3, data word width (register file and ALU).
AWIDTH, 2, register address width.
IWIDTH, 4, ALU opcode width.

Ports:
CLK  in  1  clock; all state changes on rising edge.
RST  in  1  synchronous reset, active-high.
CMD_VALID  in  1  command present.
CMD_READY  out  1  controller can accept a command.
CMD_LOAD  in  1  1 = immediate load, 0 = ALU op.
CMD_OP  in  IWIDTH  ALU opcode.
CMD_DST  in  AWIDTH  destination register.
CMD_SRCA  in  AWIDTH  source A register.
CMD_SRCB  in  AWIDTH  source B register.
CMD_IMM  in  WIDTH  immediate value.
CMD_USE_FLAG  in  1  feed stored flags into ALU Cin/Bin.
A_ADDR  out  AWIDTH  regfile read port A address.
B_ADDR  out  AWIDTH  regfile read port B address.
C_ADDR  out  AWIDTH  regfile write address.
C_WE  out  1  write enable, active-high (the top level inverts it for the regfile).
C_SEL  out  1  write-data mux select: 1 = C_DIN, 0 = ALU result.
C_DIN  out  WIDTH  immediate write data.
ALU_INSTR  out  IWIDTH  ALU opcode.
ALU_CIN  out  1  ALU carry in.
ALU_BIN  out  1  ALU borrow in.
ALU_COUT  in  1  ALU carry out.
ALU_BOUT  in  1  ALU borrow out.
CARRY_FLAG  out  1  stored carry.
BORROW_FLAG  out  1  stored borrow.
BUSY  out  1  command in flight.
DONE  out  1  one-cycle pulse, coincident with the write cycle.

Behaviour:
- FSM states: IDLE, READ, EXEC, WRITE. All outputs are registered or decoded from state and latched fields only. No combinational path exists from CMD_* to the outputs.
- Reset (RST=1 at an edge) takes effect on the next cycle:
  - state goes to IDLE;
  - all address outputs, C_DIN, ALU_INSTR, and the latched fields are 0;
  - C_WE, C_SEL, DONE, BUSY, CARRY_FLAG and BORROW_FLAG are 0;
  - CMD_READY is 0 while RST is high and 1 in IDLE afterwards.
- Acceptance: CMD_READY = (state==IDLE) and not RST. A command is accepted at an edge where CMD_VALID and CMD_READY are both 1. All CMD_* fields are latched at that edge; later changes are ignored until the next acceptance.
- ALU op (CMD_LOAD=0), acceptance at edge 0:
  - cycle 1 READ and cycle 2 EXEC: A_ADDR=SRCA, B_ADDR=SRCB, C_ADDR=DST, ALU_INSTR=OP.
  - ALU_CIN = USE_FLAG & CARRY_FLAG and ALU_BIN = USE_FLAG & BORROW_FLAG, using flag values from before this command.
  - end of EXEC (edge 3): CARRY_FLAG <= ALU_COUT and BORROW_FLAG <= ALU_BOUT.
  - cycle 3 WRITE: C_WE=1, C_SEL=0, DONE=1. Addresses and opcode are held. ALU_CIN and ALU_BIN are held at their READ-cycle values, not the just-updated flags, so the result is stable.
  - cycle 4: IDLE, CMD_READY=1. Throughput is one ALU op per 4 cycles.
- Immediate load (CMD_LOAD=1):
  - IDLE goes directly to WRITE; cycle 1: C_WE=1, C_SEL=1, C_DIN=IMM, C_ADDR=DST, DONE=1.
  - cycle 2: IDLE. Throughput is one load per 2 cycles.
  - Flags are unchanged.
- BUSY=1 in READ, EXEC and WRITE.
- C_WE is asserted for exactly one cycle per command and never outside WRITE.
- Outside WRITE, C_SEL=0. Addresses and ALU_INSTR hold their last latched values in IDLE.
- DST may equal SRCA or SRCB: the read occurs before the write, so the old value is used.
- Reset mid-operation: in any state, RST aborts the command. If RST is high during WRITE, C_WE drops the next cycle and no further write occurs. Flags clear.
- CMD_VALID held high continuously: the next command is accepted at the first IDLE edge.

Test Plan:
1. Reset then immediate load: LOAD=1, DST=1, IMM=5 accepted at edge 0 -> cycle 1 has C_WE=1, C_SEL=1, C_ADDR=1, C_DIN=5, DONE=1; cycle 2 has CMD_READY=1; flags stay 0.
2. ALU op: LOAD=0, OP=4'h5, SRCA=0, SRCB=1, DST=2, USE_FLAG=0, with the bench driving ALU_COUT=1 -> A_ADDR=0, B_ADDR=1, ALU_INSTR=5 in cycles 1-3; C_WE=1 and C_SEL=0 only in cycle 3; CARRY_FLAG=1 from cycle 3; READY back in cycle 4.
3. Flag chaining: after test 2, an ALU op with USE_FLAG=1 -> ALU_CIN=1 in cycles 1-3. The same op with USE_FLAG=0 -> ALU_CIN=0.
4. Back-to-back: CMD_VALID held high with a load then an ALU op -> accepts at edges 0 and 2; C_WE high in cycles 1 and 5 only.
5. Field stability: toggle all CMD_* during cycles 1-3 of an ALU op -> addresses, opcode and C_DIN are unchanged.
6. Reset during EXEC (cycle 2) -> cycle 3 is IDLE; C_WE never asserted; CARRY_FLAG=BORROW_FLAG=0; CMD_READY=1 once RST is low.
